cdc_fifo_wr_side: RTL and testbench



---
 rtl/cdc_fifo_pkg.sv | 34 +++
 rtl/cdc_ptr_sync.sv | 28 ++
 rtl/cdc_fifo_wr_side.sv | 108 ++++++++++
 tb/tb_cdc_fifo_wr_side.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_fifo_pkg.sv
// Shared helpers for the split dual-clock FIFO halves: pointer-width rule and
// binary/Gray conversion over a fixed maximum width (callers zero-extend and truncate).
package cdc_fifo_pkg;

  localparam int PTR_MAX_W = 32;
  localparam int MIN_AW    = 2;

  // Address width: ceil(log2(depth)), never below MIN_AW, so depths under 4
  // become 4 and non-powers of two round up.
  function automatic int calcAw(input int depth);
    int aw;
    aw = 0;
    for (int i = 0; i < PTR_MAX_W - 1; i++) begin
      if ((1 << aw) < depth) aw++;
    end
    return (aw < MIN_AW) ? MIN_AW : aw;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero upper bits of a zero-extended Gray code decode to zero, so the
  // full-width prefix XOR is correct for any narrower pointer.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
    logic [PTR_MAX_W-1:0] bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/cdc_ptr_sync.sv
// Multi-bit flop chain for bringing a Gray pointer into the local clock domain.
// Depth is clamped to 2..4 stages; async active-high reset clears every stage.
module cdc_ptr_sync #(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dIn,
  output logic [WIDTH-1:0] dOut
);

  localparam int DEPTH = (SYNC_STAGES < 2) ? 2 : (SYNC_STAGES > 4) ? 4 : SYNC_STAGES;

  logic [WIDTH-1:0] stageReg [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stageReg[i] <= '0;
    end else begin
      stageReg[0] <= dIn;
      for (int i = 1; i < DEPTH; i++) stageReg[i] <= stageReg[i-1];
    end
  end

  assign dOut = stageReg[DEPTH-1];

endmodule

// File: rtl/cdc_fifo_wr_side.sv
// Write-domain half of a split dual-clock FIFO: handshake, RAM write port, Gray
// write pointer export, synced read pointer, full and fill level. Optional macro
// CDC_WR_ALMOST_FULL_EN builds the registered almostFull comparator.
module cdc_fifo_wr_side
  import cdc_fifo_pkg::*;
#(
  parameter int MEM_DEPTH          = 4,
  parameter int DATA_WIDTH         = 20,
  parameter int SYNC_STAGES        = 2,
  parameter int ALMOST_FULL_THRESH = 3
) (
  input  logic                                  rst,
  input  logic                                  clk_wr,
  input  logic                                  infoInValid,
  input  logic [DATA_WIDTH-1:0]                 infoIn,
  output logic                                  readyForInfo,
  input  logic [cdc_fifo_pkg::calcAw(MEM_DEPTH):0]   rdPtrGray_in,
  output logic [cdc_fifo_pkg::calcAw(MEM_DEPTH):0]   wrPtrGray_out,
  output logic                                  ram_we,
  output logic [cdc_fifo_pkg::calcAw(MEM_DEPTH)-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0]                 ram_wdata,
  output logic [cdc_fifo_pkg::calcAw(MEM_DEPTH):0]   fillLevel,
  output logic                                  almostFull
);

  localparam int AW = calcAw(MEM_DEPTH);
  localparam int PW = AW + 1;

  // A threshold outside 1..2^AW would leave almostFull stuck.
  if (ALMOST_FULL_THRESH < 1 || ALMOST_FULL_THRESH > (1 << AW)) begin : gThreshRange
    $error("ALMOST_FULL_THRESH out of range 1..2^AW");
  end

  logic          initDone;
  logic          fullReg;
  logic          accept;
  logic [PW-1:0] wrBin;
  logic [PW-1:0] wrGray;
  logic [PW-1:0] wrBinNext;
  logic [PW-1:0] wrGrayNext;
  logic [PW-1:0] rdGraySync;
  logic [PW-1:0] rdBinSync;
  logic [PW-1:0] fullPattern;
  logic [PW-1:0] fillLevelNext;

  cdc_ptr_sync #(
    .WIDTH      (PW),
    .SYNC_STAGES(SYNC_STAGES)
  ) uRdPtrSync (
    .clk (clk_wr),
    .rst (rst),
    .dIn (rdPtrGray_in),
    .dOut(rdGraySync)
  );

  assign readyForInfo  = initDone & ~fullReg;
  assign accept        = infoInValid & readyForInfo;

  assign ram_we        = accept;
  assign ram_waddr     = wrBin[AW-1:0];
  assign ram_wdata     = infoIn;
  assign wrPtrGray_out = wrGray;

  assign wrBinNext     = wrBin + PW'(accept);
  assign wrGrayNext    = PW'(bin2gray(PTR_MAX_W'(wrBinNext)));
  assign rdBinSync     = PW'(gray2bin(PTR_MAX_W'(rdGraySync)));

  // Full when the post-write pointer sits exactly one lap ahead of the read
  // pointer: in Gray form that inverts the top two bits.
  assign fullPattern   = {~rdGraySync[AW:AW-1], rdGraySync[AW-2:0]};
  assign fillLevelNext = wrBinNext - rdBinSync;

  // ---- pointer / status register stage ----
  always_ff @(posedge clk_wr or posedge rst) begin
    if (rst) begin
      initDone  <= 1'b0;
      fullReg   <= 1'b0;
      wrBin     <= '0;
      wrGray    <= '0;
      fillLevel <= '0;
    end else begin
      initDone  <= 1'b1;
      fullReg   <= (wrGrayNext == fullPattern);
      wrBin     <= wrBinNext;
      wrGray    <= wrGrayNext;
      fillLevel <= fillLevelNext;
    end
  end

`ifdef CDC_WR_ALMOST_FULL_EN
  localparam logic [PW:0] THRESH = (PW+1)'(ALMOST_FULL_THRESH);

  logic almostFullReg;

  always_ff @(posedge clk_wr or posedge rst) begin
    if (rst) begin
      almostFullReg <= 1'b0;
    end else begin
      almostFullReg <= ({1'b0, fillLevelNext} >= THRESH);
    end
  end

  assign almostFull = almostFullReg;
`else
  assign almostFull = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_fifo_wr_side.sv
// Directed bench for cdc_fifo_wr_side (MEM_DEPTH=4, SYNC_STAGES=2): vector table
// plus hand sequences for reset release, mirrored wrap traffic and async reset.
module tb_cdc_fifo_wr_side;

  localparam int DW = 20;

`ifdef CDC_WR_ALMOST_FULL_EN
  localparam bit AF_EN = 1'b1;
`else
  localparam bit AF_EN = 1'b0;
`endif

  logic          rst;
  logic          clk_wr;
  logic          infoInValid;
  logic [DW-1:0] infoIn;
  logic          readyForInfo;
  logic [2:0]    rdPtrGray_in;
  logic [2:0]    wrPtrGray_out;
  logic          ram_we;
  logic [1:0]    ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [2:0]    fillLevel;
  logic          almostFull;

  int nAsserts = 0;
  int nFail    = 0;

  cdc_fifo_wr_side #(
    .MEM_DEPTH         (4),
    .DATA_WIDTH        (DW),
    .SYNC_STAGES       (2),
    .ALMOST_FULL_THRESH(3)
  ) dut (
    .rst          (rst),
    .clk_wr       (clk_wr),
    .infoInValid  (infoInValid),
    .infoIn       (infoIn),
    .readyForInfo (readyForInfo),
    .rdPtrGray_in (rdPtrGray_in),
    .wrPtrGray_out(wrPtrGray_out),
    .ram_we       (ram_we),
    .ram_waddr    (ram_waddr),
    .ram_wdata    (ram_wdata),
    .fillLevel    (fillLevel),
    .almostFull   (almostFull)
  );

  initial clk_wr = 1'b0;
  always #5 clk_wr = ~clk_wr;

  typedef struct {
    logic          valid;
    logic [DW-1:0] data;
    logic [2:0]    rd;
    logic          ready;
    logic          we;
    logic [1:0]    waddr;
    logic [2:0]    gray;
    logic [2:0]    fill;
    logic          af;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(logic v, logic [DW-1:0] d, logic [2:0] r, logic rdy,
                              logic w, logic [1:0] a, logic [2:0] g, logic [2:0] f,
                              logic af);
    vec_t t;
    t.valid = v; t.data = d; t.rd = r; t.ready = rdy; t.we = w;
    t.waddr = a; t.gray = g; t.fill = f; t.af = af;
    return t;
  endfunction

  function automatic logic [2:0] gray3(input int b);
    logic [2:0] x;
    x = b[2:0];
    return x ^ (x >> 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    nAsserts++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    infoInValid = 1'b1;
    infoIn = '0;
    rdPtrGray_in = '0;
    repeat (2) @(posedge clk_wr);
    #1;
    check("rst_ram_we", ram_we, 0);
    check("rst_ready", readyForInfo, 0);
    @(negedge clk_wr);
    rst = 1'b0;
    infoInValid = 1'b0;
    #1;
    check("rel_ready_pre_edge1", readyForInfo, 0);
    @(posedge clk_wr);
    #1;
    check("rel_ready_after_edge1", readyForInfo, 1);
  endtask

  initial begin
    int wraps;
    int toggles;
    logic prevMsb;

    rst = 1'b1;
    infoInValid = 1'b0;
    infoIn = '0;
    rdPtrGray_in = '0;

    //          valid data       rd      ready we waddr gray    fill af
    vecs[0]  = mk(1, 20'h11111, 3'b000, 1, 1, 2'd0, 3'b000, 3'd0, 0);
    vecs[1]  = mk(1, 20'h22222, 3'b000, 1, 1, 2'd1, 3'b001, 3'd1, 0);
    vecs[2]  = mk(1, 20'h33333, 3'b000, 1, 1, 2'd2, 3'b011, 3'd2, 0);
    vecs[3]  = mk(1, 20'h44444, 3'b000, 1, 1, 2'd3, 3'b010, 3'd3, 1);
    vecs[4]  = mk(1, 20'h55555, 3'b000, 0, 0, 2'd0, 3'b110, 3'd4, 1);
    vecs[5]  = mk(1, 20'h66666, 3'b000, 0, 0, 2'd0, 3'b110, 3'd4, 1);
    vecs[6]  = mk(0, 20'h77777, 3'b001, 0, 0, 2'd0, 3'b110, 3'd4, 1);
    vecs[7]  = mk(0, 20'h00000, 3'b001, 0, 0, 2'd0, 3'b110, 3'd4, 1);
    vecs[8]  = mk(0, 20'h00000, 3'b001, 0, 0, 2'd0, 3'b110, 3'd4, 1);
    vecs[9]  = mk(1, 20'h99999, 3'b001, 1, 1, 2'd0, 3'b110, 3'd3, 1);
    vecs[10] = mk(1, 20'hAAAAA, 3'b001, 0, 0, 2'd1, 3'b111, 3'd4, 1);
    vecs[11] = mk(0, 20'h00000, 3'b011, 0, 0, 2'd1, 3'b111, 3'd4, 1);
    vecs[12] = mk(0, 20'h00000, 3'b011, 0, 0, 2'd1, 3'b111, 3'd4, 1);
    vecs[13] = mk(0, 20'h00000, 3'b011, 0, 0, 2'd1, 3'b111, 3'd4, 1);
    vecs[14] = mk(0, 20'h00000, 3'b010, 1, 0, 2'd1, 3'b111, 3'd3, 1);
    vecs[15] = mk(0, 20'h00000, 3'b010, 1, 0, 2'd1, 3'b111, 3'd3, 1);
    vecs[16] = mk(0, 20'h00000, 3'b010, 1, 0, 2'd1, 3'b111, 3'd3, 1);
    vecs[17] = mk(0, 20'h00000, 3'b010, 1, 0, 2'd1, 3'b111, 3'd2, 0);

    // reset state and release timing
    #2;
    check("reset_wrGray", wrPtrGray_out, 0);
    check("reset_fill", fillLevel, 0);
    check("reset_af", almostFull, 0);
    doReset();

    // fill to full, read-side release, refill and drain via table
    for (int i = 0; i < 18; i++) begin
      infoInValid  = vecs[i].valid;
      infoIn       = vecs[i].data;
      rdPtrGray_in = vecs[i].rd;
      @(negedge clk_wr);
      check($sformatf("v%0d_ready", i), readyForInfo, vecs[i].ready);
      check($sformatf("v%0d_we", i), ram_we, vecs[i].we);
      check($sformatf("v%0d_waddr", i), ram_waddr, vecs[i].waddr);
      check($sformatf("v%0d_wdata", i), ram_wdata, vecs[i].data);
      check($sformatf("v%0d_wrGray", i), wrPtrGray_out, vecs[i].gray);
      check($sformatf("v%0d_fill", i), fillLevel, vecs[i].fill);
      check($sformatf("v%0d_af", i), almostFull, AF_EN ? vecs[i].af : 1'b0);
      @(posedge clk_wr);
      #1;
    end

    // mirrored reads: 20 writes, read pointer follows each write
    doReset();
    wraps = 0;
    toggles = 0;
    prevMsb = wrPtrGray_out[2];
    for (int i = 0; i < 20; i++) begin
      infoInValid = 1'b1;
      infoIn = DW'(i);
      @(negedge clk_wr);
      check($sformatf("mir%0d_ready", i), readyForInfo, 1);
      check($sformatf("mir%0d_waddr", i), ram_waddr, i % 4);
      check($sformatf("mir%0d_fill_bound", i), int'(fillLevel <= 3'd3), 1);
      @(posedge clk_wr);
      #1;
      infoInValid = 1'b0;
      rdPtrGray_in = gray3(i + 1);
      if (wrPtrGray_out == 3'b000) wraps++;
      if (wrPtrGray_out[2] != prevMsb) toggles++;
      prevMsb = wrPtrGray_out[2];
      @(negedge clk_wr);
      check($sformatf("mir%0d_idle_fill_bound", i), int'(fillLevel <= 3'd3), 1);
      @(posedge clk_wr);
      #1;
    end
    check("mir_wraps", wraps, 2);
    check("mir_msb_toggles", toggles, 5);
    check("mir_final_gray", wrPtrGray_out, gray3(20));
    repeat (4) @(posedge clk_wr);
    #1;
    check("mir_drained_fill", fillLevel, 0);
    check("mir_drained_ready", readyForInfo, 1);

    // async reset in the middle of a burst
    doReset();
    infoInValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      infoIn = DW'(32'hABC00 + i);
      @(posedge clk_wr);
      #1;
    end
    @(negedge clk_wr);
    check("mid_fill_before_rst", fillLevel, 3);
    check("mid_we_before_rst", ram_we, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", readyForInfo, 0);
    check("mid_rst_we", ram_we, 0);
    check("mid_rst_wrGray", wrPtrGray_out, 0);
    check("mid_rst_waddr", ram_waddr, 0);
    check("mid_rst_fill", fillLevel, 0);
    check("mid_rst_af", almostFull, 0);
    @(negedge clk_wr);
    rst = 1'b0;
    infoInValid = 1'b0;
    @(posedge clk_wr);
    #1;
    infoInValid = 1'b1;
    infoIn = 20'h0F0F0;
    @(negedge clk_wr);
    check("post_rst_we", ram_we, 1);
    check("post_rst_waddr", ram_waddr, 0);
    @(posedge clk_wr);
    #1;
    infoInValid = 1'b0;
    check("post_rst_wrGray", wrPtrGray_out, 3'b001);
    check("post_rst_fill", fillLevel, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
